// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_writeback_queue                                         |
// | Purpose  : Two-port write-back FIFO feeding one register-file write port,  |
// |            with youngest-entry forwarding to two read ports.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     a_valid,
    input  logic [AW-1:0]            a_addr,
    input  logic [DW-1:0]            a_data,
    input  logic                     b_valid,
    input  logic [AW-1:0]            b_addr,
    input  logic [DW-1:0]            b_data,
    output logic                     in_ready,
    input  logic                     hold,
    output logic                     we3,
    output logic [AW-1:0]            wa3,
    output logic [DW-1:0]            wd3,
    input  logic [AW-1:0]            ra1,
    input  logic [AW-1:0]            ra2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            PW     = $clog2(DEPTH);
    localparam int            CW     = PW + 1;
    localparam logic [AW-1:0] PC_REG = '1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          a_push;
    logic          b_push;
    logic          pop;
    logic [PW-1:0] tail_b;
    logic [PW-1:0] scan_idx;

    // Readiness depends on occupancy only so producers never see a combinational loop.
    assign in_ready = (count_q <= CW'(DEPTH - 2));

    // Writes to the PC-read register are consumed here and never reach the queue.
    assign a_push = a_valid && in_ready && (a_addr != PC_REG);
    assign b_push = b_valid && in_ready && (b_addr != PC_REG);
    assign tail_b = tail_q + PW'(a_push);

    assign pop  = (count_q != '0) && !hold;
    assign we3  = pop;
    assign wa3  = (count_q != '0) ? addr_q[head_q] : '0;
    assign wd3  = (count_q != '0) ? data_q[head_q] : '0;
    assign count = count_q;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (a_push) begin
                addr_d[tail_q] = a_addr;
                data_d[tail_q] = a_data;
            end
            if (b_push) begin
                addr_d[tail_b] = b_addr;
                data_d[tail_b] = b_data;
            end
            tail_d  = tail_b + PW'(b_push);
            head_d  = head_q + PW'(pop);
            count_d = count_q + CW'(a_push) + CW'(b_push) - CW'(pop);
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        fwd1     = '0;
        fwd2     = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((addr_q[scan_idx] == ra1) && (ra1 != PC_REG)) begin
                    hit1 = 1'b1;
                    fwd1 = data_q[scan_idx];
                end
                if ((addr_q[scan_idx] == ra2) && (ra2 != PC_REG)) begin
                    hit2 = 1'b1;
                    fwd2 = data_q[scan_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is qualified by count, so it carries no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regfile_writeback_queue                                      |
// | Purpose  : Directed self-checking bench for regfile_writeback_queue.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 3;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          in_ready;
    logic          hold;
    logic          we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          hit1;
    logic          hit2;
    logic [DW-1:0] fwd1;
    logic [DW-1:0] fwd2;
    logic [2:0]    count;

    int total;
    int bad;

    regfile_writeback_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
        .in_ready(in_ready), .hold(hold),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2),
        .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush   = 1'b0;
        a_valid = 1'b0;
        a_addr  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_addr  = '0;
        b_data  = '0;
        ra1     = 3'd0;
        ra2     = 3'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        hold  = 1'b0;
        reset = 1'b0;
        #12;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if ({we3, wa3, wd3} !== 36'd0) begin bad++; $display("FAIL reset_write got we=%b wa=%0d wd=%h want 0", we3, wa3, wd3); end
        total++; if ({hit1, hit2, fwd1, fwd2} !== 66'd0) begin bad++; $display("FAIL reset_fwd got h1=%b h2=%b f1=%h f2=%h want 0", hit1, hit2, fwd1, fwd2); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        hold = 1'b0;
        a_valid = 1'b1; a_addr = 3'd2; a_data = 32'h11;
        tick();
        a_valid = 1'b0;
        total++; if ({we3, wa3, wd3} !== {1'b1, 3'd2, 32'h11}) begin bad++; $display("FAIL single_write got we=%b wa=%0d wd=%h want we=1 wa=2 wd=11", we3, wa3, wd3); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", count); end
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", count); end
        total++; if (we3 !== 1'b0) begin bad++; $display("FAIL single_we_after got=%b want=0", we3); end
    endtask

    task automatic test_dual_forward();
        hold = 1'b1;
        a_valid = 1'b1; a_addr = 3'd3; a_data = 32'hAA;
        b_valid = 1'b1; b_addr = 3'd3; b_data = 32'hBB;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        ra1 = 3'd3; ra2 = 3'd5;
        #1;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL dual_count got=%0d want=2", count); end
        total++; if ({hit1, fwd1} !== {1'b1, 32'hBB}) begin bad++; $display("FAIL dual_fwd1 got hit=%b fwd=%h want hit=1 fwd=bb", hit1, fwd1); end
        total++; if ({hit2, fwd2} !== {1'b0, 32'h0}) begin bad++; $display("FAIL dual_fwd2 got hit=%b fwd=%h want hit=0 fwd=0", hit2, fwd2); end
        total++; if (we3 !== 1'b0) begin bad++; $display("FAIL dual_hold_we got=%b want=0", we3); end
        // Same-cycle inputs on the ports must not show up on the forwarding path.
        a_valid = 1'b1; a_addr = 3'd5; a_data = 32'h55;
        #1;
        total++; if (hit2 !== 1'b0) begin bad++; $display("FAIL dual_bypass got hit2=%b want=0", hit2); end
        a_valid = 1'b0;
        hold = 1'b0;
        #1;
        total++; if ({we3, wa3, wd3} !== {1'b1, 3'd3, 32'hAA}) begin bad++; $display("FAIL dual_first got we=%b wa=%0d wd=%h want we=1 wa=3 wd=aa", we3, wa3, wd3); end
        tick();
        total++; if ({we3, wa3, wd3} !== {1'b1, 3'd3, 32'hBB}) begin bad++; $display("FAIL dual_second got we=%b wa=%0d wd=%h want we=1 wa=3 wd=bb", we3, wa3, wd3); end
        tick();
        total++; if ({count, we3} !== {3'd0, 1'b0}) begin bad++; $display("FAIL dual_drained got count=%0d we=%b want 0 0", count, we3); end
        ra1 = 3'd0; ra2 = 3'd0;
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] exp_a [3];
        exp_a[0] = 3'd2; exp_a[1] = 3'd4; exp_a[2] = 3'd5;
        hold = 1'b1;
        a_valid = 1'b1; a_addr = 3'd1; a_data = 32'h1;
        b_valid = 1'b1; b_addr = 3'd2; b_data = 32'h2;
        tick();
        total++; if ({count, in_ready} !== {3'd2, 1'b1}) begin bad++; $display("FAIL bp_two got count=%0d rdy=%b want 2 1", count, in_ready); end
        b_valid = 1'b0;
        a_addr = 3'd4; a_data = 32'h4;
        tick();
        total++; if ({count, in_ready} !== {3'd3, 1'b0}) begin bad++; $display("FAIL bp_three got count=%0d rdy=%b want 3 0", count, in_ready); end
        a_addr = 3'd5; a_data = 32'h5;
        tick();
        tick();
        ra1 = 3'd5;
        #1;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL bp_stall_count got=%0d want=3", count); end
        total++; if (hit1 !== 1'b0) begin bad++; $display("FAIL bp_stall_hit got=%b want=0", hit1); end
        hold = 1'b0;
        tick();
        hold = 1'b1;
        #1;
        total++; if ({count, in_ready, wa3} !== {3'd2, 1'b1, 3'd2}) begin bad++; $display("FAIL bp_pop got count=%0d rdy=%b wa=%0d want 2 1 2", count, in_ready, wa3); end
        tick();
        a_valid = 1'b0;
        total++; if ({count, hit1, fwd1} !== {3'd3, 1'b1, 32'h5}) begin bad++; $display("FAIL bp_accept got count=%0d hit=%b fwd=%h want 3 1 5", count, hit1, fwd1); end
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({we3, wa3} !== {1'b1, exp_a[i]}) begin bad++; $display("FAIL bp_drain%0d got we=%b wa=%0d want we=1 wa=%0d", i, we3, wa3, exp_a[i]); end
            tick();
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL bp_empty got=%0d want=0", count); end
        ra1 = 3'd0;
    endtask

    task automatic test_pc_discard();
        hold = 1'b0;
        a_valid = 1'b1; a_addr = 3'd7; a_data = 32'hFF;
        ra1 = 3'd7;
        tick();
        a_valid = 1'b0;
        total++; if ({count, we3} !== {3'd0, 1'b0}) begin bad++; $display("FAIL pc_discard got count=%0d we=%b want 0 0", count, we3); end
        total++; if ({hit1, fwd1} !== {1'b0, 32'h0}) begin bad++; $display("FAIL pc_hit got hit=%b fwd=%h want 0 0", hit1, fwd1); end
        // Mixed pair: r7 on A is dropped while B is still queued.
        hold = 1'b1;
        a_valid = 1'b1; a_addr = 3'd7; a_data = 32'hFF;
        b_valid = 1'b1; b_addr = 3'd6; b_data = 32'h66;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        total++; if ({count, wa3, wd3} !== {3'd1, 3'd6, 32'h66}) begin bad++; $display("FAIL pc_mixed got count=%0d wa=%0d wd=%h want 1 6 66", count, wa3, wd3); end
        hold = 1'b0;
        tick();
        ra1 = 3'd0;
    endtask

    task automatic test_flush();
        hold = 1'b1;
        a_valid = 1'b1; a_addr = 3'd1; a_data = 32'h21;
        b_valid = 1'b1; b_addr = 3'd2; b_data = 32'h22;
        tick();
        b_valid = 1'b0;
        a_addr = 3'd3; a_data = 32'h23;
        tick();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_fill got=%0d want=3", count); end
        hold = 1'b0;
        flush = 1'b1;
        #1;
        total++; if ({we3, wa3} !== {1'b1, 3'd1}) begin bad++; $display("FAIL flush_cycle_we got we=%b wa=%0d want 1 1", we3, wa3); end
        tick();
        total++; if ({count, we3, in_ready} !== {3'd0, 1'b0, 1'b1}) begin bad++; $display("FAIL flush_clear got count=%0d we=%b rdy=%b want 0 0 1", count, we3, in_ready); end
        // Flush while a push is ready must still leave the queue empty.
        flush = 1'b1; a_addr = 3'd4; a_data = 32'h24;
        tick();
        flush = 1'b0; a_valid = 1'b0;
        total++; if ({count, we3} !== {3'd0, 1'b0}) begin bad++; $display("FAIL flush_push got count=%0d we=%b want 0 0", count, we3); end
    endtask

    task automatic test_reset_mid_drain();
        hold = 1'b1;
        a_valid = 1'b1; a_addr = 3'd4; a_data = 32'h44;
        b_valid = 1'b1; b_addr = 3'd5; b_data = 32'h45;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        hold = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        total++; if ({count, we3, wa3, wd3} !== {3'd0, 1'b0, 3'd0, 32'd0}) begin bad++; $display("FAIL rst_async got count=%0d we=%b wa=%0d wd=%h want all 0", count, we3, wa3, wd3); end
        tick();
        reset = 1'b1;
        tick();
        total++; if ({count, we3} !== {3'd0, 1'b0}) begin bad++; $display("FAIL rst_after got count=%0d we=%b want 0 0", count, we3); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;
        hold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ad = AW'(i % 7);
            dt = 32'h100 + DW'(i);
            a_valid = 1'b1; a_addr = ad; a_data = dt;
            tick();
            a_valid = 1'b0;
            total++; if ({we3, wa3, wd3, count} !== {1'b1, ad, dt, 3'd1}) begin bad++; $display("FAIL wrap%0d got we=%b wa=%0d wd=%h cnt=%0d want 1 %0d %h 1", i, we3, wa3, wd3, count, ad, dt); end
            tick();
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_end got=%0d want=0", count); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        hold  = 1'b0;
        test_reset();
        test_single_write();
        test_dual_forward();
        test_backpressure();
        test_pc_discard();
        test_flush();
        test_reset_mid_drain();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
